icache_sa: RTL and testbench

ICACHE_SA -- requirements
Module: icache_sa

---
 rtl/icache_sa_if.sv | 43 ++++
 rtl/icache_sa.sv | 239 +++++++++++++++++++++++
 tb/tb_icache_sa.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_sa_if.sv
// rtl/icache_sa_if.sv - fetch-side and memory-side signal bundle for icache_sa
//
// Signals:
//   rdy        global enable (low freezes the cache)
//   req/addr   fetch request (level) and byte address
//   flush      invalidate-all request (level)
//   data_out   fetched word, done is its one-cycle valid pulse
//   busy       miss outstanding or flush pending
//   mem_rd     one-cycle read pulse, mem_addr/mem_len describe the read
//   mem_data   returned word, qualified by mem_done
//   hit_cnt    hit statistics counter
//   miss_cnt   miss statistics counter
// Modports: slave = cache side, master = requester/memory side.
interface icache_sa_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              rdy;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              busy;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [DATA_W-1:0] mem_data;
    logic              mem_done;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport slave (
        input  rdy, req, addr, flush, mem_data, mem_done,
        output data_out, done, busy, mem_rd, mem_addr, mem_len, hit_cnt, miss_cnt
    );

    modport master (
        output rdy, req, addr, flush, mem_data, mem_done,
        input  data_out, done, busy, mem_rd, mem_addr, mem_len, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - 2-way set-associative instruction cache, one word per line, LRU replacement
//
// Ports:
//   clk            clock; every state update happens on the falling edge
//   rst            synchronous active-high reset, wins over bus.rdy
//   bus (slave)    icache_sa_if bundle:
//     rdy          global enable
//     req, addr    fetch request and byte address (addr[1:0] ignored)
//     flush        invalidate all lines
//     data_out     fetched word, held until the next delivery
//     done         registered one-cycle delivery pulse
//     busy         miss outstanding / flush pending
//     mem_rd       registered one-cycle memory read pulse
//     mem_addr     word-aligned miss address, held while busy
//     mem_len      constant 2'b11 (4 bytes)
//     mem_data     fill word, valid with mem_done
//     mem_done     fill-complete pulse
//     hit_cnt      hit statistics, wraps
//     miss_cnt     miss statistics, wraps
module icache_sa #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    icache_sa_if.slave bus
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Line storage, one entry per set for each way. lru_q names the
    // least-recently-used way of the set.
    logic [SETS-1:0]             valid0_q;
    logic [SETS-1:0]             valid1_q;
    logic [SETS-1:0]             lru_q;
    logic [SETS-1:0][TAG_W-1:0]  tag0_q;
    logic [SETS-1:0][TAG_W-1:0]  tag1_q;
    logic [SETS-1:0][DATA_W-1:0] data0_q;
    logic [SETS-1:0][DATA_W-1:0] data1_q;

    logic [DATA_W-1:0] data_out_q;
    logic              done_q;
    logic              busy_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic [CNT_W-1:0]  miss_cnt_q;
    logic              pend_q;
    logic              victim_q;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               unused_addr_bits;

    logic               hit0;
    logic               hit1;
    logic               hit_any;
    logic [DATA_W-1:0]  hit_data;
    logic               victim;

    // Per-edge actions decoded from state and inputs.
    logic act_flush;
    logic act_hit;
    logic act_miss;
    logic act_deliver;
    logic act_fill;
    logic act_pend;

    assign req_idx          = bus.addr[INDEX_W+1:2];
    assign req_tag          = bus.addr[ADDR_W-1:INDEX_W+2];
    assign unused_addr_bits = ^bus.addr[1:0];

    // The fill target is recovered from the latched miss address, so no
    // separate index/tag registers are needed.
    assign fill_idx = mem_addr_q[INDEX_W+1:2];
    assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_W+2];

    // Way 0 wins if both ways ever match.
    assign hit0     = valid0_q[req_idx] && (tag0_q[req_idx] == req_tag);
    assign hit1     = valid1_q[req_idx] && (tag1_q[req_idx] == req_tag) && !hit0;
    assign hit_any  = hit0 || hit1;
    assign hit_data = hit0 ? data0_q[req_idx] : data1_q[req_idx];

    // Fill an empty way first (way 0 before way 1), otherwise evict the LRU way.
    assign victim = !valid0_q[req_idx] ? 1'b0 :
                    !valid1_q[req_idx] ? 1'b1 : lru_q[req_idx];

    // State register
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (bus.rdy) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.flush && bus.req && !hit_any) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / action decode
    always_comb begin
        act_flush   = 1'b0;
        act_hit     = 1'b0;
        act_miss    = 1'b0;
        act_deliver = 1'b0;
        act_fill    = 1'b0;
        act_pend    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    act_flush = 1'b1;
                end else if (bus.req) begin
                    act_hit  = hit_any;
                    act_miss = !hit_any;
                end
            end
            S_BUSY: begin
                if (bus.mem_done) begin
                    // The word is always delivered; a flush seen during the
                    // miss (or on this edge) suppresses the install and
                    // wipes the whole array instead.
                    act_deliver = 1'b1;
                    if (pend_q || bus.flush) begin
                        act_flush = 1'b1;
                    end else begin
                        act_fill = 1'b1;
                    end
                end else if (bus.flush) begin
                    act_pend = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath, arrays and registered outputs
    always_ff @(negedge clk) begin
        if (rst) begin
            valid0_q   <= '0;
            valid1_q   <= '0;
            lru_q      <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            pend_q     <= 1'b0;
            victim_q   <= 1'b0;
        end else if (bus.rdy) begin
            // Pulses last exactly one enabled edge.
            done_q   <= act_hit || act_deliver;
            mem_rd_q <= act_miss;

            if (act_hit) begin
                data_out_q     <= hit_data;
                lru_q[req_idx] <= hit0;
                hit_cnt_q      <= hit_cnt_q + CNT_W'(1);
            end

            if (act_miss) begin
                mem_addr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
                busy_q     <= 1'b1;
                victim_q   <= victim;
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end

            if (act_pend) begin
                pend_q <= 1'b1;
            end

            if (act_deliver) begin
                data_out_q <= bus.mem_data;
                busy_q     <= 1'b0;
                pend_q     <= 1'b0;
            end

            if (act_fill) begin
                if (victim_q) begin
                    valid1_q[fill_idx] <= 1'b1;
                    tag1_q[fill_idx]   <= fill_tag;
                    data1_q[fill_idx]  <= bus.mem_data;
                end else begin
                    valid0_q[fill_idx] <= 1'b1;
                    tag0_q[fill_idx]   <= fill_tag;
                    data0_q[fill_idx]  <= bus.mem_data;
                end
                lru_q[fill_idx] <= ~victim_q;
            end

            if (act_flush) begin
                valid0_q <= '0;
                valid1_q <= '0;
                lru_q    <= '0;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_len  = 2'b11;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - self-checking bench for icache_sa against a recency-list cache model
module tb_icache_sa;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 6;
    localparam int CNT_W   = 32;
    localparam int SETS    = 1 << INDEX_W;
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    icache_sa_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    icache_sa #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: each set holds up to two lines ordered by recency, entry 0 is
    // the most recently used. A fill pushes at the front and drops the back.
    logic [TAG_W-1:0]  m_tag [SETS][2];
    logic [DATA_W-1:0] m_dat [SETS][2];
    int                m_n   [SETS];
    int                m_hits;
    int                m_misses;

    function automatic int m_find(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tg);
        for (int k = 0; k < m_n[idx]; k++) begin
            if (m_tag[idx][k] == tg) return k;
        end
        return -1;
    endfunction

    function automatic void m_use(input logic [INDEX_W-1:0] idx, input int pos);
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
        if (pos == 1) begin
            t = m_tag[idx][0]; d = m_dat[idx][0];
            m_tag[idx][0] = m_tag[idx][1]; m_dat[idx][0] = m_dat[idx][1];
            m_tag[idx][1] = t; m_dat[idx][1] = d;
        end
    endfunction

    function automatic void m_install(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tg,
                                      input logic [DATA_W-1:0] d);
        m_tag[idx][1] = m_tag[idx][0];
        m_dat[idx][1] = m_dat[idx][0];
        m_tag[idx][0] = tg;
        m_dat[idx][0] = d;
        if (m_n[idx] < 2) m_n[idx] = m_n[idx] + 1;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) m_n[s] = 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; the DUT acts on the falling
    // edge; outputs are sampled just after the following rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters();
        chk("hit_cnt", bus.hit_cnt, m_hits);
        chk("miss_cnt", bus.miss_cnt, m_misses);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_clear();
        m_hits = 0;
        m_misses = 0;
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("mem_len", bus.mem_len, 2'b11);
        chk_counters();
    endtask

    task automatic idle_flush();
        bus.flush = 1'b1;
        bus.req   = 1'b1;
        bus.addr  = $urandom;
        tick();
        bus.flush = 1'b0;
        bus.req   = 1'b0;
        chk("iflush_done", bus.done, 0);
        chk("iflush_mem_rd", bus.mem_rd, 0);
        chk("iflush_busy", bus.busy, 0);
        chk_counters();
        m_clear();
    endtask

    // exp_hit: 1 = must hit, 0 = must miss, -1 = follow the model.
    // flush_at: wait cycle on which flush is pulsed (-1 none).
    // stall: rdy-low cycles inserted right after the request edge.
    task automatic fetch(input logic [ADDR_W-1:0] a, input int exp_hit, input int lat,
                         input int flush_at, input int stall, input logic [DATA_W-1:0] fill_d);
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   tg;
        logic [DATA_W-1:0]  exp_d;
        int                 pos;
        bit                 hit;
        bit                 pend;
        idx  = a[INDEX_W+1:2];
        tg   = a[ADDR_W-1:INDEX_W+2];
        pos  = m_find(idx, tg);
        hit  = (exp_hit >= 0) ? (exp_hit == 1) : (pos >= 0);
        pend = 1'b0;

        bus.req  = 1'b1;
        bus.addr = a;
        tick();
        bus.req  = 1'b0;
        bus.addr = $urandom;

        if (hit) begin
            exp_d = (pos >= 0) ? m_dat[idx][pos] : 'x;
            m_hits++;
            chk("hit_done", bus.done, 1);
            chk("hit_data", bus.data_out, exp_d);
            chk("hit_mem_rd", bus.mem_rd, 0);
            chk("hit_busy", bus.busy, 0);
            if (pos >= 0) m_use(idx, pos);
            if (stall > 0) begin
                bus.rdy = 1'b0; bus.req = 1'b1; bus.flush = 1'b1;
                repeat (stall) begin
                    tick();
                    chk("hstall_done", bus.done, 1);
                    chk("hstall_data", bus.data_out, exp_d);
                end
                bus.rdy = 1'b1; bus.req = 1'b0; bus.flush = 1'b0;
                tick();
                chk("hstall_done_drop", bus.done, 0);
            end
        end else begin
            m_misses++;
            chk("miss_mem_rd", bus.mem_rd, 1);
            chk("miss_addr", bus.mem_addr, {a[ADDR_W-1:2], 2'b00});
            chk("miss_busy", bus.busy, 1);
            chk("miss_done", bus.done, 0);
            if (stall > 0) begin
                bus.rdy = 1'b0; bus.req = 1'b1; bus.flush = 1'b1;
                repeat (stall) begin
                    tick();
                    chk("mstall_mem_rd", bus.mem_rd, 1);
                    chk("mstall_busy", bus.busy, 1);
                    chk("mstall_addr", bus.mem_addr, {a[ADDR_W-1:2], 2'b00});
                end
                bus.rdy = 1'b1; bus.req = 1'b0; bus.flush = 1'b0;
            end
            for (int i = 0; i < lat; i++) begin
                bus.flush = (i == flush_at);
                if (i == flush_at) pend = 1'b1;
                tick();
                bus.flush = 1'b0;
                chk("wait_mem_rd", bus.mem_rd, 0);
                chk("wait_busy", bus.busy, 1);
                chk("wait_done", bus.done, 0);
            end
            bus.mem_done = 1'b1;
            bus.mem_data = fill_d;
            tick();
            bus.mem_done = 1'b0;
            bus.mem_data = $urandom;
            chk("fill_done", bus.done, 1);
            chk("fill_data", bus.data_out, fill_d);
            chk("fill_busy", bus.busy, 0);
            chk("fill_mem_rd", bus.mem_rd, 0);
            if (pend) m_clear();
            else m_install(idx, tg, fill_d);
        end
        chk_counters();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [TAG_W-1:0]  rt;
        int                lat;
        int                fa;
        int                st;

        rst          = 1'b1;
        bus.rdy      = 1'b1;
        bus.req      = 1'b0;
        bus.addr     = '0;
        bus.flush    = 1'b0;
        bus.mem_data = '0;
        bus.mem_done = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Cold miss then hit
        fetch(32'h100, 0, 3, -1, 0, 32'hDEADBEEF);
        chk("cold_miss_cnt", bus.miss_cnt, 1);
        fetch(32'h100, 1, 0, -1, 0, '0);
        chk("cold_hit_data", bus.data_out, 32'hDEADBEEF);
        chk("cold_hit_cnt", bus.hit_cnt, 1);

        // Conflict eviction of the LRU way
        do_reset();
        fetch(32'h000, 0, 1, -1, 0, $urandom);
        fetch(32'h100, 0, 2, -1, 0, $urandom);
        fetch(32'h200, 0, 1, -1, 0, $urandom);
        fetch(32'h100, 1, 0, -1, 0, '0);
        fetch(32'h000, 0, 1, -1, 0, $urandom);

        // Hit refreshes LRU
        do_reset();
        fetch(32'h000, 0, 1, -1, 0, $urandom);
        fetch(32'h100, 0, 1, -1, 0, $urandom);
        fetch(32'h000, 1, 0, -1, 0, '0);
        fetch(32'h200, 0, 2, -1, 0, $urandom);
        fetch(32'h000, 1, 0, -1, 0, '0);
        fetch(32'h100, 0, 1, -1, 0, $urandom);

        // Flush while busy: data delivered, nothing installed
        do_reset();
        fetch(32'h40, 0, 3, 1, 0, 32'h12345678);
        fetch(32'h40, 0, 2, -1, 0, 32'h9ABCDEF0);
        fetch(32'h40, 1, 0, -1, 0, '0);

        // rdy low freezes everything, on a miss and on a hit
        fetch(32'h80, 0, 2, -1, 5, 32'h0BADF00D);
        fetch(32'h80, 1, 0, -1, 3, '0);

        // Flush in IDLE invalidates
        idle_flush();
        fetch(32'h80, 0, 1, -1, 0, $urandom);

        // Reset mid-miss, then a stray mem_done
        do_reset();
        bus.req  = 1'b1;
        bus.addr = 32'h300;
        tick();
        bus.req  = 1'b0;
        chk("abort_mem_rd", bus.mem_rd, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        bus.mem_done = 1'b1;
        bus.mem_data = 32'h55555555;
        tick();
        bus.mem_done = 1'b0;
        chk("stray_done", bus.done, 0);
        chk("stray_busy", bus.busy, 0);
        chk("stray_mem_rd", bus.mem_rd, 0);
        chk("stray_data_out", bus.data_out, 0);
        chk("stray_hit_cnt", bus.hit_cnt, 0);
        chk("stray_miss_cnt", bus.miss_cnt, 0);
        m_clear();
        m_hits = 0;
        m_misses = 0;
        fetch(32'h300, 0, 1, -1, 0, $urandom);

        // Randomised traffic on a few sets and tags
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                idle_flush();
            end else begin
                rt  = ($urandom_range(0, 3) == 3) ? {TAG_W{1'b1}} : TAG_W'($urandom_range(0, 2));
                ra  = {rt, INDEX_W'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                lat = $urandom_range(0, 4);
                fa  = (lat > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
                st  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
                fetch(ra, -1, lat, fa, st, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
